player_move_input: RTL and testbench

PLAYER_MOVE_INPUT -- requirements
Module: player_move_input

---
 rtl/player_input_pkg.sv | 19 +
 rtl/btn_debounce.sv | 73 +++++++
 rtl/player_move_input.sv | 126 ++++++++++++
 tb/tb_player_move_input.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/player_input_pkg.sv
// Shared types and default sizing for the player move input block.
package player_input_pkg;

    localparam int unsigned DEF_NUM_PLAYERS  = 2;
    localparam int unsigned DEF_COL_W        = 3;
    localparam int unsigned DEF_NUM_COLS     = 7;
    localparam int unsigned DEF_DEBOUNCE_CYC = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Width of an index over n items, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One player's input path: synchronize button and switches, debounce the
// button level, and pulse press_o for one cycle on a debounced press.
module btn_debounce
    import player_input_pkg::*;
#(
    parameter int unsigned COL_W        = DEF_COL_W,
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_n_i,
    input  logic [COL_W-1:0] sw_i,
    output logic             press_o,
    output logic [COL_W-1:0] col_o
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             btn_meta_q, btn_sync_q;
    logic [COL_W-1:0] sw_meta_q, sw_sync_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    // Two-flop synchronizers; reset to the released / all-ones level.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta_q <= 1'b1;
            btn_sync_q <= 1'b1;
            sw_meta_q  <= '1;
            sw_sync_q  <= '1;
        end else begin
            btn_meta_q <= btn_n_i;
            btn_sync_q <= btn_meta_q;
            sw_meta_q  <= sw_i;
            sw_sync_q  <= sw_meta_q;
        end
    end

    // Level flips only after DEBOUNCE_CYC consecutive differing cycles; a
    // press is the high-to-low flip, so release never generates an event.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (btn_sync_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = btn_sync_q;
                press_d = level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;
    assign col_o   = sw_sync_q;

endmodule

// File: rtl/player_move_input.sv
// Captures a column move from the player whose turn it is and holds it
// until the consumer handshakes; all other confirm presses pulse reject.
module player_move_input
    import player_input_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS  = DEF_NUM_PLAYERS,
    parameter int unsigned COL_W        = DEF_COL_W,
    parameter int unsigned NUM_COLS     = DEF_NUM_COLS,
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_PLAYERS-1:0]                btn_confirm,
    input  logic [NUM_PLAYERS*COL_W-1:0]          switches,
    input  logic [idx_width(NUM_PLAYERS)-1:0]     turn,
    input  logic                                  enable,
    output logic                                  move_valid,
    input  logic                                  move_ready,
    output logic [COL_W-1:0]                      move_col,
    output logic [idx_width(NUM_PLAYERS)-1:0]     move_player,
    output logic                                  reject
);

    localparam int unsigned TURN_W = idx_width(NUM_PLAYERS);

    logic [NUM_PLAYERS-1:0] press;
    logic [COL_W-1:0]       col [NUM_PLAYERS];

    logic                   turn_press;
    logic                   other_press;
    logic [COL_W-1:0]       turn_col;
    logic                   col_ok;

    state_e                 state_q, state_d;
    logic                   valid_q, valid_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic [TURN_W-1:0]      player_q, player_d;
    logic                   reject_q, reject_d;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        btn_debounce #(
            .COL_W        (COL_W),
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_debounce (
            .clk     (clk),
            .rst     (rst),
            .btn_n_i (btn_confirm[p]),
            .sw_i    (switches[p*COL_W +: COL_W]),
            .press_o (press[p]),
            .col_o   (col[p])
        );
    end

    // Split this cycle's presses into the turn player's and everyone else's.
    always_comb begin
        turn_press  = 1'b0;
        turn_col    = '0;
        other_press = 1'b0;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            if (TURN_W'(p) == turn) begin
                turn_press = press[p];
                turn_col   = col[p];
            end else begin
                other_press = other_press | press[p];
            end
        end
    end

    assign col_ok = (32'(turn_col) < NUM_COLS);

    // Next state and output values; a single reject covers all discards.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        col_d    = col_q;
        player_d = player_q;
        reject_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (turn_press && enable && col_ok) begin
                    state_d  = ST_HOLD;
                    valid_d  = 1'b1;
                    col_d    = turn_col;
                    player_d = turn;
                    reject_d = other_press;
                end else begin
                    reject_d = turn_press | other_press;
                end
            end
            ST_HOLD: begin
                reject_d = turn_press | other_press;
                if (move_ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            col_q    <= '0;
            player_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            col_q    <= col_d;
            player_q <= player_d;
            reject_q <= reject_d;
        end
    end

    assign move_valid  = valid_q;
    assign move_col    = col_q;
    assign move_player = player_q;
    assign reject      = reject_q;

endmodule

// File: tb/tb_player_move_input.sv
// Directed bench for player_move_input with default parameters.
module tb_player_move_input;

    localparam int unsigned NP = 2;
    localparam int unsigned CW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [NP-1:0]   btn_confirm;
    logic [NP*CW-1:0] switches;
    logic [0:0]      turn;
    logic            enable;
    logic            move_valid;
    logic            move_ready;
    logic [CW-1:0]   move_col;
    logic [0:0]      move_player;
    logic            reject;

    int checks   = 0;
    int failures = 0;

    player_move_input dut (
        .clk         (clk),
        .rst         (rst),
        .btn_confirm (btn_confirm),
        .switches    (switches),
        .turn        (turn),
        .enable      (enable),
        .move_valid  (move_valid),
        .move_ready  (move_ready),
        .move_col    (move_col),
        .move_player (move_player),
        .reject      (reject)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sw(input int p, input logic [CW-1:0] v);
        switches[p*CW +: CW] = v;
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_confirm = '1; switches = '0; turn = 1'b0;
        enable = 1'b1; move_ready = 1'b1;
        repeat (3) tick();
        checks++; if (move_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", move_valid); end
        checks++; if (move_col !== 3'd0) begin failures++; $display("FAIL reset_col: got %0d expected 0", move_col); end
        checks++; if (move_player !== 1'b0) begin failures++; $display("FAIL reset_player: got %0d expected 0", move_player); end
        checks++; if (reject !== 1'b0) begin failures++; $display("FAIL reset_reject: got %0b expected 0", reject); end
        rst = 1'b0;
        repeat (5) tick();
        checks++; if (move_valid !== 1'b0) begin failures++; $display("FAIL post_reset_valid: got %0b expected 0", move_valid); end
    endtask

    task automatic test_clean_press();
        int lat = 0; int rej = 0; int vld = 0;
        logic [CW-1:0] c = '0; logic [0:0] pl = '0;
        turn = 1'b0; move_ready = 1'b1; set_sw(0, 3'd3);
        btn_confirm[0] = 1'b0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            tick();
            if (reject) rej++;
            if (move_valid) begin lat = i; c = move_col; pl = move_player; end
        end
        checks++; if (lat < 18 || lat > 20) begin failures++; $display("FAIL clean_latency: got %0d expected 19", lat); end
        checks++; if (c !== 3'd3) begin failures++; $display("FAIL clean_col: got %0d expected 3", c); end
        checks++; if (pl !== 1'b0) begin failures++; $display("FAIL clean_player: got %0d expected 0", pl); end
        tick();
        checks++; if (move_valid !== 1'b0) begin failures++; $display("FAIL clean_one_cycle: got %0b expected 0", move_valid); end
        btn_confirm[0] = 1'b1;
        repeat (25) begin tick(); if (move_valid) vld++; if (reject) rej++; end
        checks++; if (rej != 0 || vld != 0) begin failures++; $display("FAIL clean_quiet: got rej=%0d vld=%0d expected 0 0", rej, vld); end
    endtask

    // Press that must be discarded; player/column/enable prepared by caller.
    task automatic test_discard(input int p, input string name);
        int rej = 0; int vld = 0;
        btn_confirm[p] = 1'b0;
        repeat (30) begin tick(); if (reject) rej++; if (move_valid) vld++; end
        btn_confirm[p] = 1'b1;
        repeat (25) begin tick(); if (reject) rej++; if (move_valid) vld++; end
        checks++; if (rej != 1) begin failures++; $display("FAIL %s_reject: got %0d pulses expected 1", name, rej); end
        checks++; if (vld != 0) begin failures++; $display("FAIL %s_valid: got %0d cycles expected 0", name, vld); end
    endtask

    task automatic test_bounce();
        int vb = 0; int va = 0; int rej = 0;
        logic [CW-1:0] c = '0;
        turn = 1'b0; move_ready = 1'b1; set_sw(0, 3'd5);
        for (int s = 0; s < 8; s++) begin
            btn_confirm[0] = (s % 2 == 0) ? 1'b0 : 1'b1;
            repeat (5) begin tick(); if (move_valid) vb++; if (reject) rej++; end
        end
        btn_confirm[0] = 1'b0;
        repeat (40) begin
            tick();
            if (reject) rej++;
            if (move_valid) begin va++; c = move_col; end
        end
        checks++; if (vb != 0) begin failures++; $display("FAIL bounce_early: got %0d moves expected 0", vb); end
        checks++; if (va != 1) begin failures++; $display("FAIL bounce_moves: got %0d expected 1", va); end
        checks++; if (c !== 3'd5) begin failures++; $display("FAIL bounce_col: got %0d expected 5", c); end
        checks++; if (rej != 0) begin failures++; $display("FAIL bounce_reject: got %0d expected 0", rej); end
        btn_confirm[0] = 1'b1;
        repeat (25) tick();
    endtask

    task automatic test_hold_wait();
        int got = 0; int bad = 0; int rej = 0; int vld = 0;
        turn = 1'b0; move_ready = 1'b0; set_sw(0, 3'd4);
        btn_confirm[0] = 1'b0;
        for (int i = 0; i < 40 && got == 0; i++) begin tick(); if (move_valid) got = 1; end
        checks++; if (got != 1) begin failures++; $display("FAIL hold_capture: got %0d expected 1", got); end
        for (int c = 1; c <= 50; c++) begin
            tick();
            if (move_valid !== 1'b1 || move_col !== 3'd4 || move_player !== 1'b0) bad++;
            if (reject) rej++;
            if (c == 1) btn_confirm[0] = 1'b1;
            if (c == 10) turn = 1'b1;
            if (c == 22) begin btn_confirm[0] = 1'b0; set_sw(0, 3'd1); end
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL hold_stable: got %0d bad cycles expected 0", bad); end
        checks++; if (rej != 1) begin failures++; $display("FAIL hold_reject: got %0d expected 1", rej); end
        move_ready = 1'b1; turn = 1'b0;
        tick();
        checks++; if (move_valid !== 1'b0) begin failures++; $display("FAIL hold_handshake: got %0b expected 0", move_valid); end
        repeat (5) begin tick(); if (move_valid) vld++; end
        checks++; if (vld != 0) begin failures++; $display("FAIL hold_no_refire: got %0d expected 0", vld); end
        btn_confirm[0] = 1'b1;
        repeat (25) tick();
    endtask

    task automatic test_reset_in_hold();
        int got = 0; int lat = 0;
        turn = 1'b0; move_ready = 1'b0; set_sw(0, 3'd2);
        btn_confirm[0] = 1'b0;
        for (int i = 0; i < 40 && got == 0; i++) begin tick(); if (move_valid) got = 1; end
        checks++; if (got != 1) begin failures++; $display("FAIL rsthold_capture: got %0d expected 1", got); end
        rst = 1'b1;
        tick();
        checks++; if (move_valid !== 1'b0) begin failures++; $display("FAIL rsthold_valid: got %0b expected 0", move_valid); end
        checks++; if (move_col !== 3'd0) begin failures++; $display("FAIL rsthold_col: got %0d expected 0", move_col); end
        checks++; if (move_player !== 1'b0) begin failures++; $display("FAIL rsthold_player: got %0d expected 0", move_player); end
        checks++; if (reject !== 1'b0) begin failures++; $display("FAIL rsthold_reject: got %0b expected 0", reject); end
        rst = 1'b0; move_ready = 1'b1;
        for (int i = 1; i <= 40 && lat == 0; i++) begin tick(); if (move_valid) lat = i; end
        checks++; if (lat < 18 || lat > 20) begin failures++; $display("FAIL held_across_reset_latency: got %0d expected 19", lat); end
        btn_confirm[0] = 1'b1;
        repeat (25) tick();
    endtask

    task automatic test_simultaneous();
        int vld = 0; int rej = 0;
        logic [CW-1:0] c = '0; logic [0:0] pl = '0;
        turn = 1'b1; move_ready = 1'b1; set_sw(0, 3'd2); set_sw(1, 3'd6);
        btn_confirm = 2'b00;
        repeat (40) begin
            tick();
            if (reject) rej++;
            if (move_valid) begin vld++; c = move_col; pl = move_player; end
        end
        checks++; if (vld != 1) begin failures++; $display("FAIL simul_moves: got %0d expected 1", vld); end
        checks++; if (c !== 3'd6) begin failures++; $display("FAIL simul_col: got %0d expected 6", c); end
        checks++; if (pl !== 1'b1) begin failures++; $display("FAIL simul_player: got %0d expected 1", pl); end
        checks++; if (rej != 1) begin failures++; $display("FAIL simul_reject: got %0d expected 1", rej); end
        btn_confirm = 2'b11;
        repeat (25) tick();
        turn = 1'b0;
    endtask

    task automatic test_back_to_back();
        int vld = 0; int rej = 0;
        logic [CW-1:0] c0 = '0; logic [CW-1:0] c1 = '0;
        turn = 1'b0; move_ready = 1'b1; set_sw(0, 3'd1);
        btn_confirm[0] = 1'b0;
        repeat (30) begin tick(); if (reject) rej++; if (move_valid) begin vld++; c0 = move_col; end end
        btn_confirm[0] = 1'b1;
        repeat (25) begin tick(); if (reject) rej++; if (move_valid) vld++; end
        set_sw(0, 3'd6);
        btn_confirm[0] = 1'b0;
        repeat (30) begin tick(); if (reject) rej++; if (move_valid) begin vld++; c1 = move_col; end end
        checks++; if (vld != 2) begin failures++; $display("FAIL b2b_moves: got %0d expected 2", vld); end
        checks++; if (c0 !== 3'd1 || c1 !== 3'd6) begin failures++; $display("FAIL b2b_cols: got %0d,%0d expected 1,6", c0, c1); end
        checks++; if (rej != 0) begin failures++; $display("FAIL b2b_reject: got %0d expected 0", rej); end
        btn_confirm[0] = 1'b1;
        repeat (25) tick();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        turn = 1'b0; set_sw(1, 3'd2);
        test_discard(1, "wrong_turn");
        set_sw(0, 3'd7);
        test_discard(0, "bad_col");
        set_sw(0, 3'd2); enable = 1'b0;
        test_discard(0, "disabled");
        enable = 1'b1;
        test_bounce();
        test_hold_wait();
        test_reset_in_hold();
        test_simultaneous();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
